// File: rtl/rom_lut_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rom_lut_pkg
//  Description : Shared widths, types and helpers for the LUT ROM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_lut_pkg;

    localparam int LUT_ADDR_W  = 8;
    localparam int LUT_DATA_W  = 8;
    localparam int LUT_NUM_REQ = 4;

    // Index width that stays legal (>=1) even for a single-entry range.
    function automatic int lut_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LUT_ID_W = lut_idx_w(LUT_NUM_REQ);

    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [LUT_DATA_W-1:0] lut_data_t;

    typedef struct packed {
        logic [LUT_ID_W-1:0] id;
        lut_data_t           data;
    } lut_rsp_t;

endpackage
`default_nettype wire

// File: rtl/rom_lut_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : rom_lut_arbiter_if
//  Description : Request/response bundle between requesters and the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_lut_arbiter_if
    import rom_lut_pkg::*;
#(
    parameter int NUM_REQ = LUT_NUM_REQ,
    parameter int ADDR_W  = LUT_ADDR_W,
    parameter int DATA_W  = LUT_DATA_W
);
    localparam int ID_W = lut_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/rom256X8.sv
`default_nettype none
// ============================================================================
//  Module      : rom256X8
//  Description : Combinational 256x8 lookup table (nibble swap, XOR 0xA5).
//  Revision    : 1.0  initial release
// ============================================================================
module rom256X8
    import rom_lut_pkg::*;
(
    input  lut_addr_t addr,
    output lut_data_t data
);

    assign data = {addr[3:0], addr[7:4]} ^ 8'hA5;

endmodule
`default_nettype wire

// File: rtl/rom_lut_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker starting at ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import rom_lut_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = lut_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        // Walk ptr, ptr+1, ... wrapping; the first set bit wins.
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_lut_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_lut_arbiter
//  Description : Round-robin sharing of one LUT ROM, two-stage valid/ready pipe.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_lut_arbiter
    import rom_lut_pkg::*;
#(
    parameter  int NUM_REQ = LUT_NUM_REQ,
    parameter  int ADDR_W  = LUT_ADDR_W,
    parameter  int DATA_W  = LUT_DATA_W,
    localparam int ID_W    = lut_idx_w(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    rom_lut_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic               s1_valid_q,  s1_valid_d;
    logic [ID_W-1:0]    s1_id_q,     s1_id_d;
    logic [ADDR_W-1:0]  rom_addr_q,  rom_addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;

    logic               w_s2_free;
    logic               w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_win_any;
    logic [ADDR_W-1:0]  w_win_addr;
    logic               w_accept;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (w_grant),
        .grant_idx (w_win_idx),
        .any       (w_win_any)
    );

    assign w_s2_free = !rsp_valid_q || bus.rsp_ready;
    assign w_s1_free = !s1_valid_q || w_s2_free;
    assign w_accept  = w_win_any && w_s1_free;

    always_comb begin
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        rom_addr_d = rom_addr_q;
        if (w_accept) begin
            rom_addr_d = w_win_addr;
            s1_id_d    = w_win_idx;
            s1_valid_d = 1'b1;
            rr_ptr_d   = (w_win_idx == ID_W'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;
        end else if (w_s2_free) begin
            s1_valid_d = 1'b0;
        end
    end

    // ROM output is combinational from rom_addr_q, so it is captured here.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q && w_s2_free) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_data_d  = rom_data;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = (w_s1_free && !rst) ? w_grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rom_addr      = rom_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_lut_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_lut_arbiter
//  Description : Scoreboard bench for rom_lut_arbiter with a rom256X8 attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_lut_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    rom_lut_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    rom_lut_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    rom256X8 u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    bit   lat_chk = 1'b0;
    exp_t exp_q[$];
    exp_t hand_q[$];
    int   grant_q[$];
    logic [NUM_REQ-1:0] acc_mask = '0;
    int   wait_cnt[NUM_REQ];
    bit   prev_stall = 1'b0;
    logic [ID_W-1:0]   prev_id;
    logic [DATA_W-1:0] prev_data;

    function automatic logic [7:0] rom_model(input logic [7:0] a);
        logic [7:0] sw;
        sw = (a << 4) | (a >> 4);
        return sw ^ 8'hA5;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [7:0] a);
        bus_if.req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic push_hand(input int id, input int data);
        exp_t h;
        h.id = id; h.data = data; h.cyc = 0;
        hand_q.push_back(h);
    endtask

    // Monitor: samples 1ns before each rising edge, i.e. what the flops see.
    initial begin
        exp_t e;
        exp_t h;
        int   w;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                acc_mask   = '0;
                prev_stall = 1'b0;
                foreach (wait_cnt[i]) wait_cnt[i] = 0;
            end else begin
                chk("ready_only_when_valid", int'(bus_if.req_ready & ~bus_if.req_valid), 0);
                chk("ready_onehot0", int'($onehot0(bus_if.req_ready)), 1);
                if (prev_stall) begin
                    chk("hold_valid", int'(bus_if.rsp_valid), 1);
                    chk("hold_id", int'(bus_if.rsp_id), int'(prev_id));
                    chk("hold_data", int'(bus_if.rsp_data), int'(prev_data));
                end
                if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                    n_rsp++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", bus_if.rsp_id, bus_if.rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", int'(bus_if.rsp_id), e.id);
                        chk("rsp_data", int'(bus_if.rsp_data), e.data);
                        if (lat_chk) chk("latency", cyc - e.cyc, 2);
                    end
                    if (hand_q.size() > 0) begin
                        h = hand_q.pop_front();
                        chk("vector_id", int'(bus_if.rsp_id), h.id);
                        chk("vector_data", int'(bus_if.rsp_data), h.data);
                    end
                end
                acc_mask = bus_if.req_valid & bus_if.req_ready;
                if (acc_mask != '0) begin
                    w = 0;
                    for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) w = i;
                    n_acc++;
                    e.id   = w;
                    e.data = int'(rom_model(bus_if.req_addr[w*ADDR_W +: ADDR_W]));
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    if (grant_q.size() > 0) chk("grant_order", w, grant_q.pop_front());
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!bus_if.req_valid[i]) begin
                        wait_cnt[i] = 0;
                    end else if (acc_mask[i]) begin
                        total++;
                        if (wait_cnt[i] > NUM_REQ-1) begin
                            bad++;
                            $display("FAIL fairness: req%0d waited %0d accepts, limit %0d", i, wait_cnt[i], NUM_REQ-1);
                        end
                        wait_cnt[i] = 0;
                    end else if (acc_mask != '0) begin
                        wait_cnt[i]++;
                    end
                end
                prev_stall = bus_if.rsp_valid && !bus_if.rsp_ready;
                prev_id    = bus_if.rsp_id;
                prev_data  = bus_if.rsp_data;
            end
            cyc++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        int t3_data[4];
        t3_data = '{8'hAF, 8'hBF, 8'h8F, 8'h9F};
        bus_if.req_valid = '0;
        bus_if.req_addr  = '0;
        bus_if.rsp_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_rsp_valid", int'(bus_if.rsp_valid), 0);
        chk("rst_rsp_id", int'(bus_if.rsp_id), 0);
        chk("rst_rsp_data", int'(bus_if.rsp_data), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        bus_if.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", int'(bus_if.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Single requester back-to-back
        a0 = n_acc;
        lat_chk = 1'b1;
        for (int k = 0; k < 3; k++) grant_q.push_back(0);
        push_hand(0, 8'hA5);
        push_hand(0, 8'hAD);
        push_hand(0, 8'h5A);
        bus_if.req_valid = 4'b0001;
        set_addr(0, 8'h00);
        @(negedge clk);
        set_addr(0, 8'h80);
        @(negedge clk);
        set_addr(0, 8'hFF);
        @(negedge clk);
        bus_if.req_valid = '0;
        repeat (5) @(negedge clk);
        lat_chk = 1'b0;
        chk("single_accepts", n_acc - a0, 3);

        // Reset mid-stream with both stages full
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 8'hA0 + 8'(i));
        bus_if.req_valid = 4'hF;
        bus_if.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("full_req_ready", int'(bus_if.req_ready), 0);
        chk("full_rsp_valid", int'(bus_if.rsp_valid), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rom_addr", int'(rom_addr), 0);
        chk("async_rsp_valid", int'(bus_if.rsp_valid), 0);
        chk("async_rsp_id", int'(bus_if.rsp_id), 0);
        chk("async_rsp_data", int'(bus_if.rsp_data), 0);
        chk("async_req_ready", int'(bus_if.req_ready), 0);
        exp_q.delete();
        hand_q.delete();
        grant_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_rsp", int'(bus_if.rsp_valid), 0);
        end
        @(negedge clk);

        // All four requesters continuously valid
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_q.push_back(i);
                push_hand(i, t3_data[i]);
            end
        end
        bus_if.req_valid = 4'hF;
        repeat (8) @(negedge clk);
        bus_if.req_valid = '0;
        repeat (5) @(negedge clk);

        // Backpressure with req0 and req1 valid
        grant_q.push_back(0);
        grant_q.push_back(1);
        push_hand(0, 8'hB4);
        push_hand(1, 8'h87);
        a0 = n_acc;
        set_addr(0, 8'h11);
        set_addr(1, 8'h22);
        bus_if.req_valid = 4'b0011;
        bus_if.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #3;
            if (k >= 2) begin
                chk("bp_req_ready", int'(bus_if.req_ready), 0);
                chk("bp_rsp_valid", int'(bus_if.rsp_valid), 1);
            end
            @(negedge clk);
        end
        chk("bp_accepts", n_acc - a0, 2);
        r0 = n_rsp;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_responses", n_rsp - r0, 2);

        // Pointer wrap: req3 alone, then req0 and req3
        grant_q.push_back(3);
        grant_q.push_back(0);
        grant_q.push_back(3);
        push_hand(3, 8'h66);
        push_hand(0, 8'hF5);
        push_hand(3, 8'h66);
        set_addr(3, 8'h3C);
        set_addr(0, 8'h05);
        bus_if.req_valid = 4'b1000;
        @(negedge clk);
        bus_if.req_valid = 4'b1001;
        repeat (2) @(negedge clk);
        bus_if.req_valid = '0;
        repeat (5) @(negedge clk);

        // Random traffic; requesters hold until accepted
        for (int c = 0; c < 2000; c++) begin
            bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus_if.req_valid[i] || acc_mask[i]) begin
                    bus_if.req_valid[i] = 1'($urandom_range(0, 1));
                    set_addr(i, 8'($urandom_range(0, 255)));
                end
            end
            @(negedge clk);
        end
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b1;
        repeat (6) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("vectors_consumed", hand_q.size(), 0);
        chk("grants_consumed", grant_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
